// File: rtl/srtc_port.sv
// -----------------------------------------------------------------------------
// srtc_port -- nibble-wide register port in front of a BCD real-time clock.
//
// A host talks to the clock through a 4-bit port:
//   * write 0xD           : enter READ mode. Successive reads return 0xF (and
//                           take a coherent snapshot of the live time), then
//                           sec1, sec10, min1, min10, hour1, hour10, day1,
//                           day10, month (binary), year1, year10,
//                           century (binary, 20xx -> 0xA) and dow.
//   * write 0xE           : enter CMD mode. The next nibble selects the command:
//                           0x0 starts a 13-nibble time write (same field order
//                           as reads), and 0x4 loads 2000-01-01 00:00:00 with
//                           dow 6. Any other nibble returns the port to idle.
//   * write 0xF           : ignored in every mode.
//
// Ports
//   clkin         in   1  sole clock, rising edge
//   rst_n         in   1  asynchronous active-low reset
//   rtc_data      in  60  live packed BCD time from the time keeper
//   reg_rd        in   1  single-cycle read strobe
//   reg_we        in   1  single-cycle write strobe
//   reg_data_in   in   4  write nibble
//   reg_data_out  out  4  registered read nibble, valid the cycle after reg_rd
//   rtc_we        out  1  one-cycle commit pulse towards the time keeper
//   rtc_data_out  out 60  time to commit, held between pulses
// -----------------------------------------------------------------------------
module srtc_port (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic [59:0] rtc_data,
    input  logic        reg_rd,
    input  logic        reg_we,
    input  logic [3:0]  reg_data_in,
    output logic [3:0]  reg_data_out,
    output logic        rtc_we,
    output logic [59:0] rtc_data_out
);

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_READ  = 2'd1,
        MODE_CMD   = 2'd2,
        MODE_WRITE = 2'd3
    } mode_e;

    localparam logic [59:0] DEFAULT_TIME = 60'h620000101000000;
    localparam logic [3:0]  LAST_PTR     = 4'd13;

    mode_e       mode_q, mode_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [59:0] shadow_q, shadow_d;
    logic [3:0]  rd_data_q, rd_data_d;
    logic        rtc_we_q, rtc_we_d;
    logic [59:0] rtc_out_q, rtc_out_d;
    logic [59:0] wr_shadow_s;

    // Field seen by the host at pointer position p (1..13). Month and century
    // are presented in binary rather than as BCD digit pairs.
    function automatic logic [3:0] read_field(input logic [59:0] t, input logic [3:0] p);
        logic [7:0] bin;
        logic [3:0] res;
        bin = 8'd0;
        res = 4'hF;
        case (p)
            4'd1:  res = t[3:0];
            4'd2:  res = t[7:4];
            4'd3:  res = t[11:8];
            4'd4:  res = t[15:12];
            4'd5:  res = t[19:16];
            4'd6:  res = t[23:20];
            4'd7:  res = t[27:24];
            4'd8:  res = t[31:28];
            4'd9: begin
                bin = ({4'd0, t[39:36]} * 8'd10) + {4'd0, t[35:32]};
                res = bin[3:0];
            end
            4'd10: res = t[43:40];
            4'd11: res = t[47:44];
            4'd12: begin
                // Century is offset by ten so that 20xx fits a nibble as 0xA.
                bin = ({4'd0, t[55:52]} * 8'd10) + {4'd0, t[51:48]} - 8'd10;
                res = bin[3:0];
            end
            4'd13: res = t[59:56];
            default: res = 4'hF;
        endcase
        return res;
    endfunction

    // Shadow time with the field at pointer position p replaced by nibble n,
    // converting binary month and century back into BCD digit pairs.
    function automatic logic [59:0] write_field(input logic [59:0] t, input logic [3:0] p,
                                                input logic [3:0] n);
        logic [59:0] r;
        logic [7:0]  cen;
        logic [7:0]  lo;
        r   = t;
        cen = {4'd0, n} + 8'd10;
        lo  = 8'd0;
        case (p)
            4'd1:  r[3:0]   = n;
            4'd2:  r[7:4]   = n;
            4'd3:  r[11:8]  = n;
            4'd4:  r[15:12] = n;
            4'd5:  r[19:16] = n;
            4'd6:  r[23:20] = n;
            4'd7:  r[27:24] = n;
            4'd8:  r[31:28] = n;
            4'd9: begin
                if (n >= 4'd10) begin
                    r[39:36] = 4'd1;
                    r[35:32] = n - 4'd10;
                end else begin
                    r[39:36] = 4'd0;
                    r[35:32] = n;
                end
            end
            4'd10: r[43:40] = n;
            4'd11: r[47:44] = n;
            4'd12: begin
                // n+10 lies in 10..25, so the thousands digit is 1 or 2.
                if (cen >= 8'd20) begin
                    lo       = cen - 8'd20;
                    r[55:52] = 4'd2;
                end else begin
                    lo       = cen - 8'd10;
                    r[55:52] = 4'd1;
                end
                r[51:48] = lo[3:0];
            end
            4'd13: r[59:56] = n;
            default: r = t;
        endcase
        return r;
    endfunction

    assign wr_shadow_s = write_field(shadow_q, ptr_q, reg_data_in);

    // State register: mode, pointer, shadow time and all registered outputs.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_IDLE;
            ptr_q     <= 4'd0;
            shadow_q  <= 60'd0;
            rd_data_q <= 4'hF;
            rtc_we_q  <= 1'b0;
            rtc_out_q <= 60'd0;
        end else begin
            mode_q    <= mode_d;
            ptr_q     <= ptr_d;
            shadow_q  <= shadow_d;
            rd_data_q <= rd_data_d;
            rtc_we_q  <= rtc_we_d;
            rtc_out_q <= rtc_out_d;
        end
    end

    // Next-state decode. A write strobe wins over a simultaneous read strobe.
    always_comb begin
        mode_d    = mode_q;
        ptr_d     = ptr_q;
        shadow_d  = shadow_q;
        rd_data_d = rd_data_q;
        rtc_we_d  = 1'b0;
        rtc_out_d = rtc_out_q;
        if (reg_we) begin
            case (reg_data_in)
                4'hD: begin
                    mode_d = MODE_READ;
                    ptr_d  = 4'd0;
                end
                4'hE: begin
                    // Also abandons a half-written time without committing it.
                    mode_d = MODE_CMD;
                    ptr_d  = 4'd0;
                end
                4'hF: begin
                    mode_d = mode_q;
                end
                default: begin
                    case (mode_q)
                        MODE_CMD: begin
                            if (reg_data_in == 4'h0) begin
                                mode_d   = MODE_WRITE;
                                ptr_d    = 4'd1;
                                shadow_d = rtc_data;
                            end else if (reg_data_in == 4'h4) begin
                                rtc_we_d  = 1'b1;
                                rtc_out_d = DEFAULT_TIME;
                                mode_d    = MODE_IDLE;
                            end else begin
                                mode_d = MODE_IDLE;
                            end
                        end
                        MODE_WRITE: begin
                            if (ptr_q == LAST_PTR) begin
                                shadow_d  = wr_shadow_s;
                                rtc_we_d  = 1'b1;
                                rtc_out_d = wr_shadow_s;
                                mode_d    = MODE_IDLE;
                                ptr_d     = 4'd0;
                            end else if ((ptr_q != 4'd0) && (ptr_q < LAST_PTR)) begin
                                shadow_d = wr_shadow_s;
                                ptr_d    = ptr_q + 4'd1;
                            end else begin
                                mode_d = MODE_IDLE;
                                ptr_d  = 4'd0;
                            end
                        end
                        default: begin
                            mode_d = mode_q;
                        end
                    endcase
                end
            endcase
        end else if (reg_rd) begin
            if (mode_q == MODE_READ) begin
                if (ptr_q == 4'd0) begin
                    // Freeze the live time so one read sweep is self-consistent.
                    rd_data_d = 4'hF;
                    shadow_d  = rtc_data;
                    ptr_d     = 4'd1;
                end else if (ptr_q < LAST_PTR) begin
                    rd_data_d = read_field(shadow_q, ptr_q);
                    ptr_d     = ptr_q + 4'd1;
                end else begin
                    rd_data_d = read_field(shadow_q, ptr_q);
                    ptr_d     = 4'd0;
                end
            end else begin
                rd_data_d = 4'hF;
            end
        end else begin
            mode_d = mode_q;
        end
    end

    assign reg_data_out = rd_data_q;
    assign rtc_we       = rtc_we_q;
    assign rtc_data_out = rtc_out_q;

endmodule

// File: tb/tb_srtc_port.sv
module tb_srtc_port;

    logic        clkin;
    logic        rst_n;
    logic [59:0] rtc_data;
    logic        reg_rd;
    logic        reg_we;
    logic [3:0]  reg_data_in;
    logic [3:0]  reg_data_out;
    logic        rtc_we;
    logic [59:0] rtc_data_out;

    localparam logic [59:0] TIME_A   = 60'h020231231235958;
    localparam logic [59:0] TIME_B   = 60'h319991130224517;
    localparam logic [59:0] WR1_TIME = 60'h321240915012345;
    localparam logic [59:0] WR2_TIME = 60'h610991031235959;
    localparam logic [59:0] DEF_TIME = 60'h620000101000000;

    typedef struct {
        logic        we;
        logic        rd;
        logic [3:0]  din;
        logic [3:0]  exp_rd;
        logic        exp_we;
        logic        chk_data;
        logic [59:0] exp_data;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   we_cnt   = 0;
    int   cnt0;

    srtc_port dut (
        .clkin        (clkin),
        .rst_n        (rst_n),
        .rtc_data     (rtc_data),
        .reg_rd       (reg_rd),
        .reg_we       (reg_we),
        .reg_data_in  (reg_data_in),
        .reg_data_out (reg_data_out),
        .rtc_we       (rtc_we),
        .rtc_data_out (rtc_data_out)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Count commit pulses as seen at each rising edge.
    always @(posedge clkin) begin
        if (rtc_we === 1'b1) we_cnt <= we_cnt + 1;
    end

    function automatic void add(input logic we, input logic rd, input logic [3:0] din,
                                input logic [3:0] exp_rd, input logic exp_we,
                                input logic chk_data, input logic [59:0] exp_data);
        vec_t v;
        v.we = we; v.rd = rd; v.din = din; v.exp_rd = exp_rd;
        v.exp_we = exp_we; v.chk_data = chk_data; v.exp_data = exp_data;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [59:0] act, input logic [59:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock with the given strobes; returns 1 time unit after the edge.
    task automatic step(input logic we, input logic rd, input logic [3:0] din);
        reg_we = we; reg_rd = rd; reg_data_in = din;
        @(posedge clkin);
        #1;
        reg_we = 1'b0; reg_rd = 1'b0; reg_data_in = 4'h0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] exp);
        step(1'b0, 1'b1, 4'h0);
        check(name, {56'd0, reg_data_out}, {56'd0, exp});
    endtask

    task automatic wr(input logic [3:0] n);
        step(1'b1, 1'b0, n);
    endtask

    task automatic async_reset;
        rst_n = 1'b0;
        #1;
        check("rst reg_data_out", {56'd0, reg_data_out}, {56'd0, 4'hF});
        check("rst rtc_we", {59'd0, rtc_we}, 60'd0);
        check("rst rtc_data_out", rtc_data_out, 60'd0);
        @(negedge clkin);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rexp_a[15] = '{4'hF, 4'h8, 4'h5, 4'h9, 4'h5, 4'h3, 4'h2, 4'h1,
                                   4'h3, 4'hC, 4'h3, 4'h2, 4'hA, 4'h0, 4'hF};
        logic [3:0] wr1[13]    = '{4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h5, 4'h1,
                                   4'h9, 4'h4, 4'h2, 4'hB, 4'h3};
        logic [3:0] wr2[14]    = '{4'h9, 4'h5, 4'h9, 4'h5, 4'h3, 4'h2, 4'hF, 4'h1,
                                   4'h3, 4'hA, 4'h9, 4'h9, 4'h0, 4'h6};
        logic [3:0] rexp_b[13] = '{4'h7, 4'h1, 4'h5, 4'h4, 4'h2, 4'h2, 4'h0, 4'h3,
                                   4'hB, 4'h9, 4'h9, 4'h9, 4'h3};
        vec_t v;

        reg_rd = 1'b0; reg_we = 1'b0; reg_data_in = 4'h0;
        rtc_data = TIME_A;
        rst_n = 1'b1;
        #1;
        async_reset();

        // ---- vector table ----
        add(1'b1, 1'b0, 4'hD, 4'hF, 1'b0, 1'b0, 60'd0);
        for (int i = 0; i < 15; i++) add(1'b0, 1'b1, 4'h0, rexp_a[i], 1'b0, 1'b0, 60'd0);
        add(1'b1, 1'b0, 4'hE, 4'hF, 1'b0, 1'b1, 60'd0);
        add(1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 60'd0);
        for (int i = 0; i < 12; i++) add(1'b1, 1'b0, wr1[i], 4'hF, 1'b0, 1'b0, 60'd0);
        add(1'b1, 1'b0, wr1[12], 4'hF, 1'b1, 1'b1, WR1_TIME);
        add(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1, WR1_TIME);
        add(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 60'd0);
        add(1'b1, 1'b0, 4'hE, 4'hF, 1'b0, 1'b1, WR1_TIME);
        add(1'b1, 1'b0, 4'h4, 4'hF, 1'b1, 1'b1, DEF_TIME);
        add(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, DEF_TIME);
        add(1'b1, 1'b0, 4'hD, 4'hF, 1'b0, 1'b0, 60'd0);
        add(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 60'd0);
        add(1'b0, 1'b1, 4'h0, 4'h8, 1'b0, 1'b0, 60'd0);
        add(1'b1, 1'b0, 4'hE, 4'h8, 1'b0, 1'b0, 60'd0);
        add(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 60'd0);
        add(1'b1, 1'b0, 4'h1, 4'hF, 1'b0, 1'b0, 60'd0);
        add(1'b1, 1'b0, 4'hE, 4'hF, 1'b0, 1'b0, 60'd0);
        add(1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 60'd0);
        for (int i = 0; i < 13; i++) add(1'b1, 1'b0, wr2[i], 4'hF, 1'b0, 1'b0, 60'd0);
        add(1'b1, 1'b0, wr2[13], 4'hF, 1'b1, 1'b1, WR2_TIME);
        add(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1, WR2_TIME);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step(v.we, v.rd, v.din);
            check($sformatf("vec%0d reg_data_out", i), {56'd0, reg_data_out}, {56'd0, v.exp_rd});
            check($sformatf("vec%0d rtc_we", i), {59'd0, rtc_we}, {59'd0, v.exp_we});
            if (v.chk_data) check($sformatf("vec%0d rtc_data_out", i), rtc_data_out, v.exp_data);
        end
        check("pulse count after table", 60'(we_cnt), 60'd3);

        // ---- snapshot coherency across a change of live time ----
        wr(4'hD);
        for (int i = 0; i < 5; i++) rd_chk($sformatf("snap pre%0d", i), rexp_a[i]);
        rtc_data = TIME_B;
        for (int i = 5; i < 14; i++) rd_chk($sformatf("snap old%0d", i), rexp_a[i]);
        rd_chk("snap wrap", 4'hF);
        for (int i = 0; i < 13; i++) rd_chk($sformatf("snap new%0d", i), rexp_b[i]);

        // ---- aborted write via 0xD ----
        cnt0 = we_cnt;
        wr(4'hE); wr(4'h0);
        for (int i = 1; i <= 6; i++) wr(4'(i));
        wr(4'hD);
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        check("abort no pulse", 60'(we_cnt), 60'(cnt0));
        check("abort data held", rtc_data_out, WR2_TIME);
        rd_chk("abort read0", 4'hF);
        rd_chk("abort read1", 4'h7);

        // ---- write aborted by reset after 12 nibbles ----
        wr(4'hE); wr(4'h0);
        for (int i = 0; i < 12; i++) wr(4'((i % 6) + 1));
        check("pre-reset rd held", {56'd0, reg_data_out}, {56'd0, 4'h7});
        #2;
        async_reset();
        wr(4'h3);
        step(1'b0, 1'b0, 4'h0);
        check("post-reset no pulse", 60'(we_cnt), 60'(cnt0));
        check("post-reset rtc_we", {59'd0, rtc_we}, 60'd0);

        // ---- reset cancels a pending commit ----
        wr(4'hE); wr(4'h0);
        for (int i = 0; i < 13; i++) wr(wr1[i]);
        check("pending rtc_we", {59'd0, rtc_we}, 60'd1);
        check("pending data", rtc_data_out, WR1_TIME);
        async_reset();

        // ---- simultaneous read and write at ptr=7 ----
        wr(4'hD);
        rd_chk("coinc r0", 4'hF);
        for (int i = 0; i < 6; i++) rd_chk($sformatf("coinc r%0d", i + 1), rexp_b[i]);
        step(1'b1, 1'b1, 4'hD);
        check("coinc rd held", {56'd0, reg_data_out}, {56'd0, 4'h2});
        rd_chk("coinc restart", 4'hF);
        rd_chk("coinc sec1", 4'h7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
